// File: rtl/cpu6_bus_pkg.sv
// Shared types and defaults for the CPU6 memory-mapped bus responder.
package cpu6_bus_pkg;

    localparam logic [15:0] DEF_BASE_ADDR   = 16'h0000;
    localparam int          DEF_DEPTH       = 4096;
    localparam int          DEF_WAIT_STATES = 2;
    localparam int          WAIT_CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_RELEASE
    } bus_state_t;

    // Offset width for a window of 'depth' bytes; never narrower than one bit.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bus_ram.sv
// Byte-wide RAM: synchronous write, asynchronous read, no reset on contents.
module bus_ram
    import cpu6_bus_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = addr_bits(DEPTH)
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    // Commit a write at the rising edge.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/bus_responder.sv
// Memory-mapped byte responder on the CPU6 bus with programmable wait states.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   ST_IDLE    | waiting for a single request that hits the window
//   ST_WAIT    | counting wait states; dropping the request aborts
//   ST_DONE    | ready pulse; write committed, read data driven
//   ST_RELEASE | read data still driven; wait for both requests low
module bus_responder
    import cpu6_bus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          DEPTH       = DEF_DEPTH,
    parameter int          WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addressBus,
    inout  wire  [7:0]  dataBus,
    input  logic        read_req,
    input  logic        write_req,
    output logic        ready,
    output logic        bus_error
);

    localparam int                    AW      = addr_bits(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WS_LOAD = WAIT_CNT_W'(WAIT_STATES);

    bus_state_t            r_state;
    bus_state_t            w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [WAIT_CNT_W-1:0] w_cnt_nxt;
    logic [AW-1:0]         r_offset;
    logic                  r_is_write;
    logic [7:0]            r_wdata;
    logic                  r_err_block;
    logic                  w_err_block_nxt;
    logic                  r_bus_error;
    logic                  w_bus_error_nxt;

    logic [15:0]           w_diff;
    logic                  w_hit;
    logic                  w_req_live;
    logic                  w_latch;
    logic                  w_mem_we;
    logic                  w_drive;
    logic [7:0]            w_rdata;

    // Modulo-2^16 distance from the base; wraps naturally across 16'hFFFF.
    assign w_diff     = addressBus - BASE_ADDR;
    assign w_hit      = {1'b0, w_diff} < 17'(DEPTH);
    assign w_req_live = r_is_write ? write_req : read_req;

    // Next-state, counter and strobe decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_latch         = 1'b0;
        w_mem_we        = 1'b0;
        w_err_block_nxt = r_err_block;
        w_bus_error_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_err_block) begin
                    // After a collision, stay put until both requests clear.
                    if (!read_req && !write_req) begin
                        w_err_block_nxt = 1'b0;
                    end
                end else if (w_hit && read_req && write_req) begin
                    w_bus_error_nxt = 1'b1;
                    w_err_block_nxt = 1'b1;
                end else if (w_hit && (read_req ^ write_req)) begin
                    w_latch     = 1'b1;
                    w_cnt_nxt   = WS_LOAD;
                    w_state_nxt = (WAIT_STATES == 0) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!w_req_live) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_cnt == WAIT_CNT_W'(1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_mem_we    = r_is_write;
                w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!read_req && !write_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counter and latched request; synchronous reset leaves the RAM alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_offset    <= '0;
            r_is_write  <= 1'b0;
            r_wdata     <= '0;
            r_err_block <= 1'b0;
            r_bus_error <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err_block <= w_err_block_nxt;
            r_bus_error <= w_bus_error_nxt;
            if (w_latch) begin
                r_offset   <= w_diff[AW-1:0];
                r_is_write <= write_req;
                r_wdata    <= dataBus;
            end
        end
    end

    bus_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_mem_we),
        .i_addr  (r_offset),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

    assign ready     = (r_state == ST_DONE);
    assign bus_error = r_bus_error;
    assign w_drive   = !r_is_write && ((r_state == ST_DONE) || (r_state == ST_RELEASE));
    assign dataBus   = w_drive ? w_rdata : 8'hzz;

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0000, meaning the first address claimed.
REQ-002 SHALL have parameter DEPTH, default 4096, meaning the bytes claimed; a power of two, at most 65536.
REQ-003 SHALL have parameter WAIT_STATES, default 2, meaning the extra cycles before ready; range 0-15.
REQ-004 SHALL have port clock  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port addressBus  in  16  CPU byte address.
REQ-007 SHALL have port dataBus  inout  8  shared CPU data bus, driven only while read data is presented.
REQ-008 SHALL have port read_req  in  1  CPU read request, level, held until ready is seen.
REQ-009 SHALL have port write_req  in  1  CPU write request, level; write data is on dataBus.
REQ-010 SHALL have port ready  out  1  one-cycle completion pulse.
REQ-011 SHALL have port bus_error  out  1  one-cycle pulse on an illegal request.

Function
REQ-012 SHALL decode hit = (addressBus - BASE_ADDR) < DEPTH, computed unsigned in 16 bits; offset = low log2(DEPTH) bits of that difference.
REQ-013 SHALL ignore requests with hit=0: no ready, no bus_error, dataBus stays Z.
REQ-014 SHALL implement states IDLE, WAIT, DONE, RELEASE.
REQ-015 In IDLE, on exactly one request with hit=1, SHALL latch offset, direction and (for writes) dataBus, load wait counter = WAIT_STATES, then go to WAIT (WAIT_STATES>0) or DONE (WAIT_STATES=0).
REQ-016 In WAIT, SHALL decrement the counter each cycle and go to DONE on the cycle the counter reaches 0.
REQ-017 In WAIT, if the latched request drops, SHALL abort to IDLE with no memory write and no ready.
REQ-018 In DONE, SHALL assert ready for exactly one cycle, commit a write at that edge, then go to RELEASE.
REQ-019 Latency: ready SHALL be high in cycle WAIT_STATES+1 after the cycle the request is first sampled.
REQ-020 For reads, SHALL drive dataBus with mem[offset] during DONE and RELEASE; Z in all other states.
REQ-021 In RELEASE, SHALL wait until both read_req and write_req are 0, then return to IDLE; no new access starts before that.
REQ-022 If read_req and write_req are both 1 in IDLE, SHALL pulse bus_error for one cycle, do no access and stay in IDLE until both drop.
REQ-023 SHALL ignore changes to addressBus and dataBus after latching, until IDLE is re-entered.
REQ-024 Memory SHALL be byte-wide with DEPTH entries; contents are undefined at power-up.

Reset
REQ-025 Reset SHALL force IDLE, ready=0, bus_error=0, counter=0 and dataBus Z at the next edge, including mid-transaction; a pending write is dropped.
REQ-026 Reset SHALL NOT clear memory contents.

Structure
REQ-027 Package cpu6_bus_pkg SHALL hold the state enum, the default constants for BASE_ADDR, DEPTH and WAIT_STATES, and the 4-bit wait-counter width.
REQ-028 Storage SHALL be one sub-module, bus_ram: a single-port synchronous-write, asynchronous-read byte RAM parameterised by DEPTH.
REQ-029 The FSM, decode and tri-state control SHALL live in bus_responder.

Verification
REQ-030 Write then read, WAIT_STATES=2, BASE=16'h0000: write 8'hA5 to 16'h0010; ready in cycle 3; read 16'h0010 returns 8'hA5 on dataBus while ready=1.
REQ-031 WAIT_STATES=0: read request in cycle 0 -> ready in cycle 1 with data valid; dataBus Z again once read_req=0.
REQ-032 Miss and wrap, BASE=16'hF000, DEPTH=4096: access 16'hEFFF -> no ready and Z; access 16'hFFFF -> hit at offset 12'hFFF; access 16'h0000 -> miss.
REQ-033 Abort: write 8'h3C to 16'h0020 dropped during WAIT -> no ready; subsequent read of 16'h0020 returns the old value.
REQ-034 Both read_req and write_req high -> bus_error pulses for 1 cycle, ready stays 0 and memory is unchanged.
REQ-035 Reset asserted in DONE of a read -> next cycle ready=0 and dataBus Z; earlier written data still reads back correctly.
